// File: rtl/cps1_sync_monitor.sv
// cps1_sync_monitor: measures CPS1 composite sync timing and reports lock.
// Define CPS1_SYNCMON_GLITCH_FILTER_EN to enable the 3-cycle CSYNC glitch filter.
module cps1_sync_monitor #(
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned H_TOL         = 2,
    parameter int unsigned MIN_LINES     = 16,
    parameter int unsigned VS_THOLD      = 256
) (
    input  logic        PCLK2x_i,
    input  logic        RST_i,
    input  logic        CSYNC_i,
    output logic [10:0] line_len_o,
    output logic [9:0]  lines_per_frame_o,
    output logic [21:0] vclks_per_frame_o,
    output logic        frame_strobe_o,
    output logic        locked_o,
    output logic        lock_lost_o,
    output logic        no_signal_o
);

    localparam int LW = $clog2(VS_THOLD + 1);
    localparam logic [LW-1:0] LOW_MAX = LW'(VS_THOLD);
    localparam logic [LW-1:0] LOW_HIT = LW'(VS_THOLD - 1);
    localparam logic [9:0]    MINL    = 10'(MIN_LINES);
    localparam logic [10:0]   HTOL    = 11'(H_TOL);
    localparam logic [3:0]    NSTAB   = 4'(STABLE_FRAMES);
    localparam logic [10:0]   LCTR_MAX = 11'h7ff;
    localparam logic [9:0]    VCTR_MAX = 10'h3ff;

    typedef enum logic [1:0] {
        S_NOSIG,
        S_MEAS,
        S_LOCK
    } state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    logic          cond;
    logic [10:0]   lctr_q, lctr_d;
    logic [LW-1:0] low_q, low_d;
    logic          long_q, long_d;
    logic [9:0]    vctr_q, vctr_d;
    logic [10:0]   line_len_q, line_len_d;
    logic [9:0]    lpf_q, lpf_d;
    logic [10:0]   plen_q, plen_d;
    logic [21:0]   mul_q, mul_d;
    logic [21:0]   vclks_q, vclks_d;
    logic          strobe_q, strobe_d;
    logic          lost_q, lost_d;
    logic          locked_q, locked_d;
    logic          nosig_q, nosig_d;
    state_t        state_q, state_d;
    logic [3:0]    stab_q, stab_d;

    logic          fall;
    logic          low;
    logic          wdog;
    logic          reach;
    logic          bound;
    logic          stable;
    logic [10:0]   hdiff;

    always_comb begin
        sync1_d = CSYNC_i;
        sync2_d = sync1_q;
        prev_d  = cond;
    end

`ifdef CPS1_SYNCMON_GLITCH_FILTER_EN
    logic       filt_q, filt_d;
    logic [1:0] fcnt_q, fcnt_d;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = 2'd0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == 2'd2) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge PCLK2x_i) begin
        if (RST_i) begin
            filt_q <= 1'b1;
            fcnt_q <= 2'd0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign cond = filt_q;
`else
    assign cond = sync2_q;
`endif

    always_comb begin
        fall   = prev_q & ~cond;
        low    = ~cond;
        wdog   = (lctr_q == LCTR_MAX);
        reach  = low && (low_q == LOW_HIT);
        // A watchdog timeout swallows any boundary on the same cycle
        bound  = reach && (vctr_q >= MINL) && !wdog;
        if (line_len_q >= plen_q) begin
            hdiff = line_len_q - plen_q;
        end else begin
            hdiff = plen_q - line_len_q;
        end
        stable = (vctr_q == lpf_q) && (hdiff <= HTOL);
    end

    always_comb begin
        lctr_d = lctr_q;
        if (fall) begin
            lctr_d = 11'd0;
        end else if (!wdog) begin
            lctr_d = lctr_q + 11'd1;
        end

        low_d = '0;
        if (low) begin
            low_d = (low_q == LOW_MAX) ? low_q : low_q + 1'b1;
        end

        long_d = long_q;
        if (fall) begin
            long_d = 1'b0;
        end else if (reach) begin
            long_d = 1'b1;
        end

        vctr_d = vctr_q;
        if (bound) begin
            vctr_d = 10'd0;
        end else if (fall && vctr_q != VCTR_MAX) begin
            vctr_d = vctr_q + 10'd1;
        end
    end

    always_comb begin
        line_len_d = line_len_q;
        if (fall && !long_q) begin
            line_len_d = lctr_q + 11'd1;
        end
        lpf_d    = bound ? vctr_q : lpf_q;
        plen_d   = bound ? line_len_q : plen_q;
        mul_d    = {11'd0, plen_q} * {12'd0, lpf_q};
        vclks_d  = mul_q;
        strobe_d = bound;
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        lost_d  = 1'b0;
        if (wdog) begin
            state_d = S_NOSIG;
            stab_d  = 4'd0;
            lost_d  = (state_q == S_LOCK);
        end else begin
            unique case (state_q)
                S_NOSIG: begin
                    if (fall) begin
                        state_d = S_MEAS;
                        stab_d  = 4'd0;
                    end
                end
                S_MEAS: begin
                    if (bound) begin
                        if (stable) begin
                            stab_d = stab_q + 4'd1;
                            if (stab_q + 4'd1 == NSTAB) begin
                                state_d = S_LOCK;
                            end
                        end else begin
                            stab_d = 4'd0;
                        end
                    end
                end
                S_LOCK: begin
                    if (bound && !stable) begin
                        state_d = S_MEAS;
                        stab_d  = 4'd0;
                        lost_d  = 1'b1;
                    end
                end
                default: state_d = S_NOSIG;
            endcase
        end
        locked_d = (state_d == S_LOCK);
        nosig_d  = (state_d == S_NOSIG);
    end

    always_ff @(posedge PCLK2x_i) begin
        if (RST_i) begin
            // Synchronizer idles high so reset never fakes a falling edge
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            lctr_q     <= 11'd0;
            low_q      <= '0;
            long_q     <= 1'b0;
            vctr_q     <= 10'd0;
            line_len_q <= 11'd0;
            lpf_q      <= 10'd0;
            plen_q     <= 11'd0;
            mul_q      <= 22'd0;
            vclks_q    <= 22'd0;
            strobe_q   <= 1'b0;
            lost_q     <= 1'b0;
            locked_q   <= 1'b0;
            nosig_q    <= 1'b1;
            state_q    <= S_NOSIG;
            stab_q     <= 4'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            lctr_q     <= lctr_d;
            low_q      <= low_d;
            long_q     <= long_d;
            vctr_q     <= vctr_d;
            line_len_q <= line_len_d;
            lpf_q      <= lpf_d;
            plen_q     <= plen_d;
            mul_q      <= mul_d;
            vclks_q    <= vclks_d;
            strobe_q   <= strobe_d;
            lost_q     <= lost_d;
            locked_q   <= locked_d;
            nosig_q    <= nosig_d;
            state_q    <= state_d;
            stab_q     <= stab_d;
        end
    end

    assign line_len_o        = line_len_q;
    assign lines_per_frame_o = lpf_q;
    assign vclks_per_frame_o = vclks_q;
    assign frame_strobe_o    = strobe_q;
    assign locked_o          = locked_q;
    assign lock_lost_o       = lost_q;
    assign no_signal_o       = nosig_q;

endmodule
